fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencer feeding a 2-entry {instruction, pc} prefetch buffer.
// Optional FETCH_ALIGN_CHECK_EN flags odd redirect targets and forces them even.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_ins,
   input  logic        redirect_en,
   input  logic [7:0]  redirect_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [15:0] ins_out,
   output logic [7:0]  ins_pc,
   output logic        align_err
);

   logic [7:0]  pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] ins_q [2];
   logic [15:0] ins_d [2];
   logic [7:0]  epc_q [2];
   logic [7:0]  epc_d [2];
   logic [7:0]  target;
   logic        push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic err_q;

   assign target    = {redirect_pc[7:1], 1'b0};
   assign align_err = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (redirect_en && redirect_pc[0]) begin
         err_q <= 1'b1;
      end
   end
`else
   assign target    = redirect_pc;
   assign align_err = 1'b0;
`endif

   assign imem_addr = pc_q;
   assign ins_valid = (count_q != 2'd0);
   assign ins_out   = ins_q[0];
   assign ins_pc    = epc_q[0];
   assign pop       = ins_valid && ins_ready;
   assign push      = ((count_q != 2'd2) || pop) && !redirect_en;

   // Slot 0 is always the head; a pop shifts slot 1 forward.
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      ins_d[0] = ins_q[0];
      ins_d[1] = ins_q[1];
      epc_d[0] = epc_q[0];
      epc_d[1] = epc_q[1];
      if (redirect_en) begin
         count_d = 2'd0;
         pc_d    = target;
      end else begin
         if (push) begin
            pc_d = pc_q + 8'd2;
         end
         unique case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  ins_d[0] = imem_ins;
                  epc_d[0] = pc_q;
               end else begin
                  ins_d[1] = imem_ins;
                  epc_d[1] = pc_q;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               ins_d[0] = ins_q[1];
               epc_d[0] = epc_q[1];
               count_d  = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  ins_d[0] = imem_ins;
                  epc_d[0] = pc_q;
               end else begin
                  ins_d[0] = ins_q[1];
                  epc_d[0] = epc_q[1];
                  ins_d[1] = imem_ins;
                  epc_d[1] = pc_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         count_q  <= 2'd0;
         ins_q[0] <= 16'h0000;
         ins_q[1] <= 16'h0000;
         epc_q[0] <= 8'h00;
         epc_q[1] <= 8'h00;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         ins_q[0] <= ins_d[0];
         ins_q[1] <= ins_d[1];
         epc_q[0] <= epc_d[0];
         epc_q[1] <= epc_d[1];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word at addr is {addr, addr+1}.
// Expected values follow FETCH_ALIGN_CHECK_EN when the bench is built with it.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [15:0] imem_ins;
   logic        redirect_en;
   logic [7:0]  redirect_pc;
   logic        ins_valid;
   logic        ins_ready;
   logic [15:0] ins_out;
   logic [7:0]  ins_pc;
   logic        align_err;

   typedef struct {
      logic       rdy;
      logic       ren;
      logic [7:0] rpc;
      logic       v;
      logic [7:0] pc;
      logic [7:0] addr;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;

   fetch_unit #(.RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_ins    (imem_ins),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .ins_out     (ins_out),
      .ins_pc      (ins_pc),
      .align_err   (align_err)
   );

   always #5 clk = ~clk;

   assign imem_ins = {imem_addr, imem_addr + 8'd1};

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic ren, input logic [7:0] rpc,
                      input logic v, input logic [7:0] pc, input logic [7:0] addr,
                      input logic err);
      vec_t r;
      r.rdy = rdy; r.ren = ren; r.rpc = rpc;
      r.v = v; r.pc = pc; r.addr = addr; r.err = err;
      vecs.push_back(r);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] b2;
      b  = ALIGN ? 8'h30 : 8'h31;
      b2 = ALIGN ? 8'hFE : 8'hFF;

      // rdy ren rpc   | v  pc     addr      err
      add(0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
      add(0, 0, 8'h00, 1, 8'h00, 8'h02, 0);
      add(0, 0, 8'h00, 1, 8'h00, 8'h04, 0);
      add(0, 0, 8'h00, 1, 8'h00, 8'h04, 0);
      add(0, 0, 8'h00, 1, 8'h00, 8'h04, 0);
      add(1, 0, 8'h00, 1, 8'h00, 8'h04, 0);
      add(1, 0, 8'h00, 1, 8'h02, 8'h06, 0);
      add(1, 0, 8'h00, 1, 8'h04, 8'h08, 0);
      add(1, 1, 8'h40, 1, 8'h06, 8'h0A, 0);
      add(1, 0, 8'h00, 0, 8'h00, 8'h40, 0);
      add(1, 0, 8'h00, 1, 8'h40, 8'h42, 0);
      add(1, 1, 8'hFC, 1, 8'h42, 8'h44, 0);
      add(1, 0, 8'h00, 0, 8'h00, 8'hFC, 0);
      add(1, 0, 8'h00, 1, 8'hFC, 8'hFE, 0);
      add(1, 0, 8'h00, 1, 8'hFE, 8'h00, 0);
      add(1, 0, 8'h00, 1, 8'h00, 8'h02, 0);
      add(1, 0, 8'h00, 1, 8'h02, 8'h04, 0);
      add(1, 1, 8'h31, 1, 8'h04, 8'h06, 0);
      add(1, 0, 8'h00, 0, 8'h00, b,     ALIGN);
      add(0, 0, 8'h00, 1, b,     b + 8'd2, ALIGN);
      add(0, 0, 8'h00, 1, b,     b + 8'd4, ALIGN);
      add(0, 0, 8'h00, 1, b,     b + 8'd4, ALIGN);
      add(0, 1, 8'hFF, 1, b,     b + 8'd4, ALIGN);
      add(1, 0, 8'h00, 0, 8'h00, b2,    ALIGN);
      add(1, 0, 8'h00, 1, b2,    b2 + 8'd2, ALIGN);
      add(1, 0, 8'h00, 1, b2 + 8'd2, b2 + 8'd4, ALIGN);
      add(0, 0, 8'h00, 1, b2 + 8'd4, b2 + 8'd6, ALIGN);
      add(0, 0, 8'h00, 1, b2 + 8'd4, b2 + 8'd8, ALIGN);

      rst = 1'b1;
      ins_ready = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {15'd0, ins_valid}, 16'd0);
      check("rst_out", ins_out, 16'h0000);
      check("rst_pc", {8'd0, ins_pc}, 16'h0000);
      check("rst_addr", {8'd0, imem_addr}, 16'h0000);
      check("rst_err", {15'd0, align_err}, 16'd0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         ins_ready   = vecs[i].rdy;
         redirect_en = vecs[i].ren;
         redirect_pc = vecs[i].rpc;
         #1;
         check($sformatf("v%0d_valid", i), {15'd0, ins_valid}, {15'd0, vecs[i].v});
         check($sformatf("v%0d_addr", i), {8'd0, imem_addr}, {8'd0, vecs[i].addr});
         check($sformatf("v%0d_err", i), {15'd0, align_err}, {15'd0, vecs[i].err});
         if (vecs[i].v) begin
            check($sformatf("v%0d_pc", i), {8'd0, ins_pc}, {8'd0, vecs[i].pc});
            check($sformatf("v%0d_out", i), ins_out, {vecs[i].pc, vecs[i].pc + 8'd1});
         end
      end

      // FIFO is full here; pulse rst between edges and expect an immediate flush.
      @(negedge clk);
      ins_ready   = 1'b1;
      redirect_en = 1'b0;
      #1;
      check("full_valid", {15'd0, ins_valid}, 16'd1);
      rst = 1'b1;
      #1;
      check("async_valid", {15'd0, ins_valid}, 16'd0);
      check("async_addr", {8'd0, imem_addr}, 16'h0000);
      check("async_out", ins_out, 16'h0000);
      check("async_pc", {8'd0, ins_pc}, 16'h0000);
      check("async_err", {15'd0, align_err}, 16'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first_valid", {15'd0, ins_valid}, 16'd1);
      check("first_pc", {8'd0, ins_pc}, 16'h0000);
      check("first_out", ins_out, 16'h0001);
      check("first_addr", {8'd0, imem_addr}, 16'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
